scs8hd_lpflow_clkdivkapwr: RTL

- Multi-channel clock divider on the keep-alive (kapwr) domain.
- Produces NCH divided clocks, each optionally inverted, from one always-on source clock.
- Per-channel divide ratio is programmable. Ratio changes and enable changes take effect only at full-period boundaries, so outputs never produce runt pulses or glitches.
- Sits beside the lpflow clock inverters and feeds slow clocks to retention and wake-up logic that must keep running while vpwr is collapsed.

---
 rtl/scs8hd_lpflow_clkdivkapwr_if.sv | 22 ++
 rtl/scs8hd_lpflow_clkdivkapwr.sv | 109 ++++++++++
 2 files changed

// File: rtl/scs8hd_lpflow_clkdivkapwr_if.sv
// Control/status bundle for the keep-alive clock divider: run requests,
// divide values and load strobe in; divided clocks and activity flags out.
interface scs8hd_lpflow_clkdivkapwr_if #(
  parameter int NCH  = 4,
  parameter int DIVW = 4
);
  logic [NCH-1:0]      EN;
  logic [NCH*DIVW-1:0] DIV;
  logic                LOAD;
  logic [NCH-1:0]      Y;
  logic [NCH-1:0]      ACTIVE;

  modport master (
    output EN, DIV, LOAD,
    input  Y, ACTIVE
  );

  modport slave (
    input  EN, DIV, LOAD,
    output Y, ACTIVE
  );
endinterface

// File: rtl/scs8hd_lpflow_clkdivkapwr.sv
// Multi-channel glitch-free clock divider on the always-on (kapwr) domain.
// Optional sleep handshake (SLEEP/SLPACK) enabled by SC_LPFLOW_CLKDIV_SLEEP_EN.
module scs8hd_lpflow_clkdivkapwr #(
  parameter int NCH    = 4,
  parameter int DIVW   = 4,
  parameter int INVERT = 1
) (
`ifdef SC_USE_PG_PIN
  input  logic kapwr,
  input  logic vpwr,
  input  logic vgnd,
  input  logic vpb,
  input  logic vnb,
`endif
  input  logic CLK,
  input  logic RESET,
`ifdef SC_LPFLOW_CLKDIV_SLEEP_EN
  input  logic SLEEP,
  output logic SLPACK,
`endif
  scs8hd_lpflow_clkdivkapwr_if.slave bus
);

  localparam logic INV_L = (INVERT != 0);

  logic [NCH-1:0][DIVW-1:0] shadow_q, shadow_d;
  logic [NCH-1:0][DIVW-1:0] div_act_q, div_act_d;
  logic [NCH-1:0][DIVW-1:0] cnt_q, cnt_d;
  logic [NCH-1:0]           t_q, t_d;
  logic [NCH-1:0]           run_q, run_d;
  logic [NCH-1:0]           en_eff;
  logic                     sleep_w;

`ifdef SC_LPFLOW_CLKDIV_SLEEP_EN
  assign sleep_w = SLEEP;
`else
  assign sleep_w = 1'b0;
`endif

  // Sleep masks every run request, so channels park at their next boundary.
  assign en_eff = bus.EN & ~{NCH{sleep_w}};

  always_comb begin
    shadow_d  = shadow_q;
    div_act_d = div_act_q;
    cnt_d     = cnt_q;
    t_d       = t_q;
    run_d     = run_q;
    for (int c = 0; c < NCH; c++) begin
      if (bus.LOAD) begin
        shadow_d[c] = bus.DIV[c*DIVW +: DIVW];
      end
      if (!run_q[c]) begin
        div_act_d[c] = shadow_q[c];
        if (en_eff[c]) begin
          run_d[c] = 1'b1;
          cnt_d[c] = '0;
        end
      end else if (cnt_q[c] == div_act_q[c]) begin
        cnt_d[c] = '0;
        t_d[c]   = ~t_q[c];
        // Falling t edge closes a period: only here may ratio or run change.
        if (t_q[c]) begin
          div_act_d[c] = shadow_q[c];
          if (!en_eff[c]) begin
            run_d[c] = 1'b0;
          end
        end
      end else begin
        cnt_d[c] = cnt_q[c] + DIVW'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      shadow_q  <= '0;
      div_act_q <= '0;
      cnt_q     <= '0;
      t_q       <= '0;
      run_q     <= '0;
    end else begin
      shadow_q  <= shadow_d;
      div_act_q <= div_act_d;
      cnt_q     <= cnt_d;
      t_q       <= t_d;
      run_q     <= run_d;
    end
  end

  // XOR with a constant is a plain inverter or wire: Y stays a flop output.
  assign bus.Y      = t_q ^ {NCH{INV_L}};
  assign bus.ACTIVE = run_q;

`ifdef SC_LPFLOW_CLKDIV_SLEEP_EN
  logic slpack_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      slpack_q <= 1'b0;
    end else begin
      slpack_q <= sleep_w & ~|run_q;
    end
  end

  assign SLPACK = slpack_q;
`endif

endmodule
